// File: rtl/word_ram_responder.sv
// Converts 32-bit/byte word requests into one or two big-endian 16-bit memory
// commands with ready/valid handshaking, and assembles returned read data.
`timescale 1ns/1ps
module word_ram_responder #(
  parameter int unsigned MEM_AW = 24
) (
  input  logic              clk_sys,
  input  logic              reset_l,
  input  logic              word_rd,
  input  logic              word_wr,
  input  logic              word_32bit,
  input  logic [25:0]       word_addr,
  input  logic [31:0]       word_data,
  output logic [31:0]       word_q,
  output logic              word_busy,
  output logic              err_overrun,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_d,
  input  logic              mem_ready,
  input  logic              mem_qvalid,
  input  logic [15:0]       mem_q
);

  localparam int unsigned WORD_AW = 26;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {IDLE, CMD_HI, CMD_LO, WAIT_Q} state_t;

  state_t              state, state_d;
  logic                req_we, req_we_d;
  logic                req_32, req_32_d;
  logic [15:0]         req_lo, req_lo_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [31:0]         word_q_d;
  logic                err_d;
  logic                mem_req_d, mem_we_d;
  logic [1:0]          mem_be_d;
  logic [MEM_AW-1:0]   mem_addr_d;
  logic [15:0]         mem_d_d;
  logic                pulse;
  logic                q_done;
  logic                unused_addr_hi;

  assign pulse          = word_rd | word_wr;
  assign word_busy      = (state != IDLE) | pulse;
  assign unused_addr_hi = ^word_addr[WORD_AW-1:MEM_AW+1];

  // State and all registered outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_l) begin
      state       <= IDLE;
      req_we      <= 1'b0;
      req_32      <= 1'b0;
      req_lo      <= 16'h0;
      cnt         <= CNT_W'(0);
      word_q      <= 32'h0;
      err_overrun <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 2'b00;
      mem_addr    <= MEM_AW'(0);
      mem_d       <= 16'h0;
    end else begin
      state       <= state_d;
      req_we      <= req_we_d;
      req_32      <= req_32_d;
      req_lo      <= req_lo_d;
      cnt         <= cnt_d;
      word_q      <= word_q_d;
      err_overrun <= err_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_be      <= mem_be_d;
      mem_addr    <= mem_addr_d;
      mem_d       <= mem_d_d;
    end
  end

  // Next state, next command fields and read-data assembly
  always_comb begin
    state_d    = state;
    req_we_d   = req_we;
    req_32_d   = req_32;
    req_lo_d   = req_lo;
    cnt_d      = cnt;
    word_q_d   = word_q;
    err_d      = err_overrun | (pulse & (state != IDLE));
    mem_req_d  = mem_req;
    mem_we_d   = mem_we;
    mem_be_d   = mem_be;
    mem_addr_d = mem_addr;
    mem_d_d    = mem_d;
    q_done     = 1'b0;

    // Returns are only meaningful once the HI command has been accepted
    if ((state == CMD_LO || state == WAIT_Q) && !req_we && mem_qvalid) begin
      if (!req_32) begin
        word_q_d = {mem_q, mem_q};
        q_done   = 1'b1;
      end else if (cnt == CNT_W'(0)) begin
        word_q_d[31:16] = mem_q;
        cnt_d           = CNT_W'(1);
      end else begin
        word_q_d[15:0] = mem_q;
        cnt_d          = CNT_W'(2);
        q_done         = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (pulse) begin
          state_d   = CMD_HI;
          req_we_d  = word_wr;
          req_32_d  = word_32bit;
          req_lo_d  = word_data[15:0];
          mem_req_d = 1'b1;
          mem_we_d  = word_wr;
          if (word_32bit) begin
            mem_addr_d = {word_addr[MEM_AW:2], 1'b0};
            mem_be_d   = 2'b11;
            mem_d_d    = word_data[31:16];
          end else begin
            mem_addr_d = word_addr[MEM_AW:1];
            mem_be_d   = word_addr[0] ? 2'b01 : 2'b10;
            mem_d_d    = word_data[15:0];
          end
        end
      end
      CMD_HI: begin
        if (mem_ready) begin
          if (req_32) begin
            state_d       = CMD_LO;
            mem_addr_d[0] = 1'b1;
            mem_d_d       = req_lo;
          end else begin
            mem_req_d = 1'b0;
            state_d   = req_we ? IDLE : WAIT_Q;
          end
        end
      end
      CMD_LO: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = (req_we || q_done) ? IDLE : WAIT_Q;
        end
      end
      WAIT_Q: begin
        if (q_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) cnt_d = CNT_W'(0);
  end

endmodule

// File: tb/tb_word_ram_responder.sv
// Scoreboard bench for word_ram_responder: expected memory commands and
// completion read data are queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_word_ram_responder;

  logic        clk_sys = 1'b0;
  logic        reset_l;
  logic        word_rd, word_wr, word_32bit;
  logic [25:0] word_addr;
  logic [31:0] word_data;
  logic [31:0] word_q;
  logic        word_busy, err_overrun;
  logic        mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [23:0] mem_addr;
  logic [15:0] mem_d;
  logic        mem_ready, mem_qvalid;
  logic [15:0] mem_q;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [23:0] addr;
    logic [15:0] d;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_q = 32'h0;
  int          checks = 0;
  int          errors = 0;

  word_ram_responder #(.MEM_AW(24)) dut (
    .clk_sys(clk_sys), .reset_l(reset_l),
    .word_rd(word_rd), .word_wr(word_wr), .word_32bit(word_32bit),
    .word_addr(word_addr), .word_data(word_data), .word_q(word_q),
    .word_busy(word_busy), .err_overrun(err_overrun),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_ready(mem_ready),
    .mem_qvalid(mem_qvalid), .mem_q(mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_cmd(input logic we, input logic [1:0] be,
                                   input logic [23:0] addr, input logic [15:0] d);
    cmd_t c;
    c.we = we; c.be = be; c.addr = addr; c.d = d;
    exp_cmd.push_back(c);
  endfunction

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  // Cycle after the pulse at which busy first reads low for a stalled 32-bit write
  function automatic int exp_low_wr32(input logic [31:0] rmask);
    int hi = -1;
    int lo = -1;
    for (int c = 1; c < 64 && lo < 0; c++) begin
      logic r;
      r = (c < 32) ? rmask[c] : 1'b1;
      if (r && hi < 0) hi = c;
      else if (r) lo = c;
    end
    return lo + 1;
  endfunction

  // Pulse a request in cycle 0, drive ready/qvalid per cycle, measure busy-low cycle
  task automatic run_req(input string name, input logic rd, input logic wr, input logic is32,
                         input logic [25:0] addr, input logic [31:0] data,
                         input logic [31:0] rmask, input int qv0, input int qv1,
                         input logic [15:0] qd0, input logic [15:0] qd1,
                         input int ovr, input int exp_low);
    int low = -1;
    next_cycle();
    word_rd = rd; word_wr = wr; word_32bit = is32; word_addr = addr; word_data = data;
    for (int c = 0; c < 64 && low < 0; c++) begin
      if (c > 0) begin
        next_cycle();
        word_rd = 1'b0; word_wr = 1'b0;
        if (c == ovr) begin
          word_wr = 1'b1; word_32bit = 1'b1; word_addr = 26'h300; word_data = 32'hFFFFFFFF;
        end
      end
      mem_ready  = (c < 32) ? rmask[c] : 1'b1;
      mem_qvalid = (c == qv0) || (c == qv1);
      mem_q      = (c == qv1) ? qd1 : qd0;
      @(negedge clk_sys);
      if (c == 0) chk({name, "_busy_on_pulse"}, 64'(word_busy), 64'(1));
      else if (!word_busy) low = c;
    end
    word_rd = 1'b0; word_wr = 1'b0; mem_qvalid = 1'b0; mem_ready = 1'b1;
    chk({name, "_busy_low_cycle"}, 64'(low), 64'(exp_low));
  endtask

  // Monitor: command scoreboard, hold stability, and completion data
  logic        prev_busy = 1'b0;
  logic        hold_valid = 1'b0;
  logic [43:0] hold_fields = '0;
  cmd_t        e;
  logic [31:0] eq;
  always @(negedge clk_sys) begin
    if (hold_valid)
      chk("cmd_stable", 64'({mem_req, mem_we, mem_be, mem_addr, mem_d}), 64'(hold_fields));
    if (reset_l && mem_req && mem_ready) begin
      if (exp_cmd.size() == 0) begin
        chk("cmd_unexpected", 64'({mem_we, mem_be, mem_addr, mem_d}), 64'(0));
      end else begin
        e = exp_cmd.pop_front();
        chk("cmd_fields", 64'({mem_we, mem_be, mem_addr, (mem_we ? mem_d : 16'h0)}),
            64'({e.we, e.be, e.addr, (e.we ? e.d : 16'h0)}));
      end
    end
    hold_valid  = reset_l && mem_req && !mem_ready;
    hold_fields = {mem_req, mem_we, mem_be, mem_addr, mem_d};
    if (prev_busy && !word_busy) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(1), 64'(0));
      end else begin
        eq = exp_q.pop_front();
        chk("word_q_done", 64'(word_q), 64'(eq));
      end
    end
    prev_busy = word_busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rmask;
    reset_l = 1'b0; word_rd = 1'b0; word_wr = 1'b0; word_32bit = 1'b0;
    word_addr = '0; word_data = '0; mem_ready = 1'b1; mem_qvalid = 1'b0; mem_q = '0;
    repeat (2) next_cycle();
    @(negedge clk_sys);
    chk("rst_word_q", 64'(word_q), 64'(0));
    chk("rst_req_busy_err", 64'({mem_req, mem_we, word_busy, err_overrun}), 64'(0));
    chk("rst_be_addr_d", 64'({mem_be, mem_addr, mem_d}), 64'(0));
    next_cycle();
    reset_l = 1'b1;

    push_cmd(1'b1, 2'b11, 24'h8, 16'hDEAD);
    push_cmd(1'b1, 2'b11, 24'h9, 16'hBEEF);
    exp_q.push_back(last_q);
    run_req("wr32", 1'b0, 1'b1, 1'b1, 26'h10, 32'hDEADBEEF, '1, -1, -1, 16'h0, 16'h0, -1, 3);

    push_cmd(1'b1, 2'b01, 24'h10, 16'h5A5A);
    exp_q.push_back(last_q);
    run_req("wrb_odd", 1'b0, 1'b1, 1'b0, 26'h21, 32'h5A5A5A5A, '1, -1, -1, 16'h0, 16'h0, -1, 2);

    push_cmd(1'b1, 2'b10, 24'h10, 16'h5A5A);
    exp_q.push_back(last_q);
    run_req("wrb_even", 1'b0, 1'b1, 1'b0, 26'h20, 32'h5A5A5A5A, '1, -1, -1, 16'h0, 16'h0, -1, 2);

    push_cmd(1'b0, 2'b11, 24'h8, 16'h0);
    push_cmd(1'b0, 2'b11, 24'h9, 16'h0);
    last_q = 32'h12345678;
    exp_q.push_back(last_q);
    run_req("rd32", 1'b1, 1'b0, 1'b1, 26'h10, 32'h0, '1, 3, 4, 16'h1234, 16'h5678, -1, 5);

    push_cmd(1'b1, 2'b11, 24'h80, 16'hCAFE);
    push_cmd(1'b1, 2'b11, 24'h81, 16'hF00D);
    exp_q.push_back(last_q);
    run_req("wr32_stall", 1'b0, 1'b1, 1'b1, 26'h100, 32'hCAFEF00D, 32'hFFFFFFE9,
            -1, -1, 16'h0, 16'h0, -1, 6);

    rmask = $urandom();
    push_cmd(1'b1, 2'b11, 24'h91A, 16'h0F1E);
    push_cmd(1'b1, 2'b11, 24'h91B, 16'h2D3C);
    exp_q.push_back(last_q);
    run_req("wr32_rand", 1'b0, 1'b1, 1'b1, 26'h1234, 32'h0F1E2D3C, rmask,
            -1, -1, 16'h0, 16'h0, -1, exp_low_wr32(rmask));
    chk("err_clear_before_ovr", 64'(err_overrun), 64'(0));

    push_cmd(1'b1, 2'b11, 24'h100, 16'h1111);
    push_cmd(1'b1, 2'b11, 24'h101, 16'h2222);
    exp_q.push_back(last_q);
    run_req("wr32_ovr", 1'b0, 1'b1, 1'b1, 26'h200, 32'h11112222, '1, -1, -1, 16'h0, 16'h0, 1, 3);
    chk("err_overrun_set", 64'(err_overrun), 64'(1));

    // Reset while waiting for read data; late returns must be ignored
    push_cmd(1'b0, 2'b11, 24'h20, 16'h0);
    push_cmd(1'b0, 2'b11, 24'h21, 16'h0);
    last_q = 32'h0;
    exp_q.push_back(last_q);
    next_cycle();
    word_rd = 1'b1; word_32bit = 1'b1; word_addr = 26'h40; mem_ready = 1'b1;
    next_cycle(); word_rd = 1'b0;
    next_cycle();
    next_cycle(); reset_l = 1'b0;
    @(negedge clk_sys);
    chk("busy_in_wait_q", 64'(word_busy), 64'(1));
    next_cycle(); reset_l = 1'b1; mem_qvalid = 1'b1; mem_q = 16'hAAAA;
    @(negedge clk_sys);
    chk("mid_rst_ctrl", 64'({mem_req, mem_we, word_busy, err_overrun}), 64'(0));
    chk("mid_rst_fields", 64'({mem_be, mem_addr, mem_d}), 64'(0));
    chk("mid_rst_word_q", 64'(word_q), 64'(0));
    next_cycle(); mem_q = 16'hBBBB;
    next_cycle(); mem_qvalid = 1'b0;
    @(negedge clk_sys);
    chk("late_qvalid_ignored", 64'(word_q), 64'(0));

    push_cmd(1'b0, 2'b11, 24'h20, 16'h0);
    push_cmd(1'b0, 2'b11, 24'h21, 16'h0);
    last_q = 32'h0BADF00D;
    exp_q.push_back(last_q);
    run_req("rd32_after_rst", 1'b1, 1'b0, 1'b1, 26'h40, 32'h0, '1, 3, 4, 16'h0BAD, 16'hF00D, -1, 5);

    push_cmd(1'b0, 2'b01, 24'h10, 16'h0);
    last_q = 32'h00C300C3;
    exp_q.push_back(last_q);
    run_req("rdb", 1'b1, 1'b0, 1'b0, 26'h21, 32'h0, '1, 3, -1, 16'h00C3, 16'h0, -1, 4);

    next_cycle(); mem_qvalid = 1'b1; mem_q = 16'h9999;
    next_cycle(); mem_qvalid = 1'b0;
    @(negedge clk_sys);
    chk("idle_qvalid_ignored", 64'(word_q), 64'(32'h00C300C3));

    push_cmd(1'b1, 2'b10, 24'h11, 16'h7777);
    exp_q.push_back(last_q);
    run_req("rdwr_both", 1'b1, 1'b1, 1'b0, 26'h22, 32'h77777777, '1, -1, -1, 16'h0, 16'h0, -1, 2);

    push_cmd(1'b0, 2'b11, 24'h8, 16'h0);
    push_cmd(1'b0, 2'b11, 24'h9, 16'h0);
    last_q = 32'h11112222;
    exp_q.push_back(last_q);
    run_req("rd32_q_in_lo", 1'b1, 1'b0, 1'b1, 26'h10, 32'h0, 32'hFFFFFFFB,
            2, 4, 16'h1111, 16'h2222, -1, 5);

    repeat (3) next_cycle();
    chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'(0));
    chk("resp_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
